// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, branch types and
// the iterative multiplier state enum.
package exe_pkg;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0001;
  localparam logic [3:0] CMD_AND = 4'b0010;
  localparam logic [3:0] CMD_OR  = 4'b0011;
  localparam logic [3:0] CMD_NOR = 4'b0100;
  localparam logic [3:0] CMD_XOR = 4'b0101;
  localparam logic [3:0] CMD_SLL = 4'b0110;
  localparam logic [3:0] CMD_SRL = 4'b0111;
  localparam logic [3:0] CMD_SRA = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1001;
  localparam logic [3:0] CMD_SLT = 4'b1010;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/exe_stage_iter_mul.sv
// Shift-and-add multiplier: one issue cycle, 32 BUSY cycles, one DONE cycle.
// Operands are latched at issue so upstream forwarding may change freely.
module iter_mul
  import exe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p,
  output mul_state_t       state
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] mcand, mplier, product;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        MUL_IDLE: if (start) begin
          mcand   <= a;
          mplier  <= b;
          product <= '0;
          cnt     <= '0;
        end
        MUL_BUSY: begin
          if (mplier[0]) product <= product + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // DONE never looks at start, so the instruction that is completing
  // cannot launch a second multiply.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL_IDLE: if (start) state_d = MUL_BUSY;
      MUL_BUSY: if (cnt == LAST) state_d = MUL_DONE;
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  assign busy  = ((state_q == MUL_IDLE) && start) || (state_q == MUL_BUSY);
  assign done  = (state_q == MUL_DONE);
  assign p     = product;
  assign state = state_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: MEM/WB operand forwarding, single-cycle ALU, iterative
// multiply with pipeline stall, and branch resolution.
module exe_stage
  import exe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             wb_en,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       br,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] reg2,
  input  logic             imm,
  input  logic [4:0]       dest,
  input  logic [4:0]       src1,
  input  logic [4:0]       src2,
  input  logic [4:0]       mem_dest,
  input  logic [4:0]       wb_dest,
  input  logic             mem_wb_en,
  input  logic             wb_wb_en,
  input  logic [WIDTH-1:0] mem_val,
  input  logic [WIDTH-1:0] wb_val,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] st_val,
  output logic             wb_en_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic [4:0]       dest_out,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_addr,
  output logic             stall,
  output mul_state_t       mul_state
);

  logic             fwd_a_mem, fwd_a_wb, fwd_b_mem, fwd_b_wb;
  logic [WIDTH-1:0] fb_val, op_a, op_b;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_p;

  // R0 is hardwired zero, so a match on register 0 must never forward.
  assign fwd_a_mem = mem_wb_en && (mem_dest == src1) && (src1 != 5'd0);
  assign fwd_a_wb  = wb_wb_en  && (wb_dest  == src1) && (src1 != 5'd0);
  assign fwd_b_mem = mem_wb_en && (mem_dest == src2) && (src2 != 5'd0);
  assign fwd_b_wb  = wb_wb_en  && (wb_dest  == src2) && (src2 != 5'd0);

  always_comb begin
    op_a = data1;
    if (fwd_a_mem)     op_a = mem_val;
    else if (fwd_a_wb) op_a = wb_val;

    fb_val = data2;
    st_val = reg2;
    if (fwd_b_mem) begin
      fb_val = mem_val;
      st_val = mem_val;
    end else if (fwd_b_wb) begin
      fb_val = wb_val;
      st_val = wb_val;
    end
    op_b = imm ? data2 : fb_val;
  end

  iter_mul #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (exe_cmd == CMD_MUL),
    .a     (op_a),
    .b     (op_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p),
    .state (mul_state)
  );

  always_comb begin
    alu_result = '0;
    case (exe_cmd)
      CMD_ADD: alu_result = op_a + op_b;
      CMD_SUB: alu_result = op_a - op_b;
      CMD_AND: alu_result = op_a & op_b;
      CMD_OR:  alu_result = op_a | op_b;
      CMD_NOR: alu_result = ~(op_a | op_b);
      CMD_XOR: alu_result = op_a ^ op_b;
      CMD_SLL: alu_result = op_a << op_b[4:0];
      CMD_SRL: alu_result = op_a >> op_b[4:0];
      CMD_SRA: alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
      CMD_MUL: alu_result = mul_done ? mul_p : '0;
      CMD_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (br)
      BR_BEZ:  br_taken = (op_a == '0);
      BR_BNE:  br_taken = (op_a != st_val);
      BR_JMP:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
    if (stall) br_taken = 1'b0;
  end

  assign br_addr  = pc_in + data2;
  assign stall    = mul_busy;
  assign dest_out = dest;

  // Bubbles into EXE/MEM while the multiplier holds the pipe.
  assign wb_en_out     = wb_en     && !stall;
  assign mem_read_out  = mem_read  && !stall;
  assign mem_write_out = mem_write && !stall;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with an expected-result queue for alu_result.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        wb_en, mem_read, mem_write;
  logic [1:0]  br;
  logic [3:0]  exe_cmd;
  logic [31:0] data1, data2, reg2;
  logic        imm;
  logic [4:0]  dest, src1, src2, mem_dest, wb_dest;
  logic        mem_wb_en, wb_wb_en;
  logic [31:0] mem_val, wb_val;
  logic [31:0] alu_result, st_val, br_addr;
  logic        wb_en_out, mem_read_out, mem_write_out, br_taken, stall;
  logic [4:0]  dest_out;
  mul_state_t  mul_state;

  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_stall;

  exe_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en(wb_en), .mem_read(mem_read),
    .mem_write(mem_write), .br(br), .exe_cmd(exe_cmd), .data1(data1),
    .data2(data2), .reg2(reg2), .imm(imm), .dest(dest), .src1(src1),
    .src2(src2), .mem_dest(mem_dest), .wb_dest(wb_dest), .mem_wb_en(mem_wb_en),
    .wb_wb_en(wb_wb_en), .mem_val(mem_val), .wb_val(wb_val),
    .alu_result(alu_result), .st_val(st_val), .wb_en_out(wb_en_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .dest_out(dest_out), .br_taken(br_taken), .br_addr(br_addr),
    .stall(stall), .mul_state(mul_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s observed=%h expected=<empty queue>", tag, alu_result);
    end else begin
      e = exp_q.pop_front();
      chk(tag, alu_result, e);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    pc_in = 32'h0; wb_en = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    br = BR_NONE; exe_cmd = CMD_ADD; data1 = '0; data2 = '0; reg2 = '0;
    imm = 1'b1; dest = 5'd9; src1 = 5'd1; src2 = 5'd2; mem_dest = 5'd0;
    wb_dest = 5'd0; mem_wb_en = 1'b0; wb_wb_en = 1'b0; mem_val = '0; wb_val = '0;
  endtask

  task automatic alu_step(input string tag, input logic [3:0] cmd,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    @(negedge clk);
    exe_cmd = cmd; data1 = a; data2 = b; imm = 1'b1;
    exp_q.push_back(exp);
    #1;
    check_result(tag);
  endtask

  // Counts stall cycles from the issue sample; after the first cycle the
  // forwarding source disappears, which latched operands must tolerate.
  task automatic wait_mul(output int n);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      chk("bubble_wb_en", {31'b0, wb_en_out}, 32'd0);
      n++;
      @(negedge clk); #1;
      if (n == 1) begin mem_wb_en = 1'b0; mem_val = 32'h0; end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_state", {30'b0, mul_state}, {30'b0, MUL_IDLE});
    chk("reset_br_taken", {31'b0, br_taken}, 32'd0);
    rst = 1'b0;

    alu_step("add", CMD_ADD, 32'd5, 32'd7, 32'd12);
    chk("add_stall", {31'b0, stall}, 32'd0);
    chk("add_br_taken", {31'b0, br_taken}, 32'd0);
    chk("add_wb_en", {31'b0, wb_en_out}, 32'd1);
    chk("dest_out", {27'b0, dest_out}, 32'd9);

    // forwarding priority on operand A
    @(negedge clk);
    src1 = 5'd3; mem_dest = 5'd3; wb_dest = 5'd3; mem_wb_en = 1'b1; wb_wb_en = 1'b1;
    mem_val = 32'hAA; wb_val = 32'hBB;
    alu_step("fwd_mem_prio", CMD_SUB, 32'h55, 32'h0A, 32'hA0);
    mem_wb_en = 1'b0;
    alu_step("fwd_wb", CMD_SUB, 32'h55, 32'h0A, 32'hB1);
    mem_wb_en = 1'b1; src1 = 5'd0; mem_dest = 5'd0; wb_dest = 5'd0;
    alu_step("fwd_r0_raw", CMD_SUB, 32'h55, 32'h0A, 32'h4B);

    // forwarding on operand B (register form)
    @(negedge clk);
    src1 = 5'd1; src2 = 5'd4; mem_dest = 5'd6; wb_dest = 5'd4;
    mem_wb_en = 1'b1; wb_wb_en = 1'b1; wb_val = 32'h0000_0100; reg2 = 32'h1;
    exe_cmd = CMD_OR; data1 = 32'h0000_0011; data2 = 32'h0000_0022; imm = 1'b0;
    exp_q.push_back(32'h0000_0111);
    #1;
    check_result("fwd_b_wb");
    chk("st_val_wb", st_val, 32'h0000_0100);
    idle_inputs();

    alu_step("sra", CMD_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_step("srl", CMD_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_step("sll", CMD_SLL, 32'h0000_0003, 32'd31, 32'h8000_0000);
    alu_step("slt_neg", CMD_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_step("slt_pos", CMD_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0);
    alu_step("nor", CMD_NOR, 32'h0F0F_0000, 32'h0000_F0F0, 32'hF0F0_0F0F);
    alu_step("xor", CMD_XOR, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'hF00F_0FF0);
    alu_step("and", CMD_AND, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0FF0_0000);
    alu_step("sub_wrap", CMD_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
    alu_step("undef_cmd", 4'b1111, 32'h1234, 32'h5678, 32'd0);

    // branches
    @(negedge clk);
    br = BR_BNE; data1 = 32'd4; reg2 = 32'd4; src2 = 5'd0; #1;
    chk("bne_not_taken", {31'b0, br_taken}, 32'd0);
    @(negedge clk);
    src1 = 5'd1; src2 = 5'd7; mem_dest = 5'd7; mem_wb_en = 1'b1; mem_val = 32'd5;
    pc_in = 32'h100; data2 = 32'h20; imm = 1'b1; #1;
    chk("bne_st_val", st_val, 32'd5);
    chk("bne_taken", {31'b0, br_taken}, 32'd1);
    chk("br_addr", br_addr, 32'h120);
    @(negedge clk);
    idle_inputs(); br = BR_BEZ; data1 = 32'd0; #1;
    chk("bez_taken", {31'b0, br_taken}, 32'd1);
    @(negedge clk); data1 = 32'd1; #1;
    chk("bez_not_taken", {31'b0, br_taken}, 32'd0);
    @(negedge clk); br = BR_JMP; #1;
    chk("jmp_taken", {31'b0, br_taken}, 32'd1);

    // MUL with operand A forwarded from MEM, then withdrawn mid-multiply
    @(negedge clk);
    idle_inputs();
    src1 = 5'd5; mem_dest = 5'd5; mem_wb_en = 1'b1; mem_val = 32'hFFFF_FFFF;
    exe_cmd = CMD_MUL; data1 = 32'h0; data2 = 32'd3; imm = 1'b1; br = BR_JMP;
    exp_q.push_back(32'hFFFF_FFFD);
    #1;
    chk("mul_issue_stall", {31'b0, stall}, 32'd1);
    chk("mul_issue_br_gated", {31'b0, br_taken}, 32'd0);
    wait_mul(n_stall);
    chk("mul_stall_cycles", n_stall, 32'd33);
    check_result("mul_result");
    chk("mul_done_wb_en", {31'b0, wb_en_out}, 32'd1);
    chk("mul_done_state", {30'b0, mul_state}, {30'b0, MUL_DONE});

    // back-to-back MUL: new instruction arrives the cycle after DONE
    @(negedge clk);
    br = BR_NONE; src1 = 5'd1; data1 = 32'h0001_2345; data2 = 32'h10;
    exp_q.push_back(32'h0012_3450);
    #1;
    chk("mul2_issue_stall", {31'b0, stall}, 32'd1);
    wait_mul(n_stall);
    chk("mul2_stall_cycles", n_stall, 32'd33);
    check_result("mul2_result");

    // reset in BUSY cycle 10 aborts the multiply
    @(negedge clk);
    data1 = 32'd9; data2 = 32'd9;
    repeat (10) @(negedge clk);
    #1;
    chk("busy_state", {30'b0, mul_state}, {30'b0, MUL_BUSY});
    @(negedge clk);
    rst = 1'b1; exe_cmd = CMD_ADD;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_state", {30'b0, mul_state}, {30'b0, MUL_IDLE});

    @(negedge clk);
    exe_cmd = CMD_MUL; data1 = 32'd6; data2 = 32'd7;
    exp_q.push_back(32'd42);
    #1;
    wait_mul(n_stall);
    chk("mul3_stall_cycles", n_stall, 32'd33);
    check_result("mul3_result");
    @(negedge clk);
    exe_cmd = CMD_ADD; #1;
    chk("post_mul_idle", {30'b0, mul_state}, {30'b0, MUL_IDLE});

    // final report
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage pipeline. It sits between the ID/EXE and EXE/MEM pipeline registers. It forwards operands from the MEM and WB stages, runs the single-cycle ALU and a 33-cycle iterative multiplier, and resolves branches. The block is combinational on the single-cycle path. Its sequential part is the multiplier FSM, which raises `stall` to freeze IF, ID and ID/EXE while a multiply completes.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `CNT_W`, 6, multiplier iteration counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `pc_in`  in  32  PC+4 of the instruction.
- `wb_en`, `mem_read`, `mem_write`  in  1 each  control from ID/EXE.
- `br`  in  2  branch type: 00 none, 01 BEZ, 10 BNE, 11 JMP.
- `exe_cmd`  in  4  ALU operation.
- `data1`, `data2`  in  32  operand A and operand B (B may be an immediate).
- `reg2`  in  32  rs2 register value, used for stores and BNE.
- `imm`  in  1  1 = `data2` is an immediate; carried by ID/EXE.
- `dest`, `src1`, `src2`  in  5  register numbers.
- `mem_dest`, `wb_dest`  in  5  destination registers in MEM and WB.
- `mem_wb_en`, `wb_wb_en`  in  1  write enables in MEM and WB.
- `mem_val`, `wb_val`  in  32  forwardable results from MEM and WB.
- `alu_result`  out  32  result to EXE/MEM.
- `st_val`  out  32  forwarded `reg2` value.
- `wb_en_out`, `mem_read_out`, `mem_write_out`  out  1  control to EXE/MEM, gated by stall.
- `dest_out`  out  5  equals `dest`.
- `br_taken`  out  1  flush request for IF/ID and ID/EXE.
- `br_addr`  out  32  branch target.
- `stall`  out  1  freeze request for IF, ID and ID/EXE.

## Operation
Forwarding, applied independently to `src1` (gives fa) and `src2` (gives fb):
- MEM value is selected if `mem_wb_en`, the register numbers match, and the register is nonzero.
- Otherwise the WB value is selected under the same conditions.
- Otherwise the raw input is used.
- MEM has priority over WB. R0 is never forwarded.

Operands:
- opA = fa applied to `data1`.
- opB = `data2` if `imm`, else fb applied to `data2`.
- `st_val` = fb applied to `reg2`.

`exe_cmd` encoding (all arithmetic modulo 2^32):
- 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 NOR; 0101 XOR.
- 0110 SLL; 0111 SRL; 1000 SRA. Shift amount is opB[4:0].
- 1001 MUL: low 32 bits of the product, multi-cycle.
- 1010 SLT: signed compare, result 1 or 0.
- Any other code gives 0.

Branches:
- `br_addr` = `pc_in` + `data2`. ID has already sign-extended and shifted the offset.
- `br_taken` = (01 and opA==0) or (10 and opA!=st_val) or 11.
- `br_taken` is forced to 0 while `stall`=1.

Multiplier FSM, states IDLE, BUSY, DONE:
- IDLE, when `exe_cmd`=1001: latch opA into mcand and opB into mplier, clear product and counter, go to BUSY. `stall`=1 in this cycle.
- BUSY: each cycle, add mcand to product if mplier[0]=1; shift mcand left 1 and mplier right 1; increment counter. After the 32nd BUSY cycle go to DONE. `stall`=1 throughout.
- DONE: `alu_result` = product and `stall`=0. Return to IDLE next cycle, with no re-trigger on the same instruction.

Stall and reset behaviour:
- While `stall`=1, `wb_en_out`, `mem_read_out` and `mem_write_out` are forced to 0, so EXE/MEM captures bubbles.
- Operands are latched at issue, so MEM/WB draining during the stall cannot corrupt them.
- On `rst`: state=IDLE; product, mcand, mplier and counter are 0; `stall`=0. Reset mid-multiply aborts the multiply with no partial result.

## Timing
- Single-cycle ops: zero latency, combinational from inputs to outputs.
- MUL issued in cycle t:
  - `stall`=1 in cycles t..t+32 (33 cycles).
  - Result and control pass to EXE/MEM in cycle t+33.
  - ID/EXE advances at the edge ending t+33.
- Back-to-back MULs: the second MUL is seen in IDLE in the cycle after DONE, so each MUL costs 34 cycles total.
- Branch resolves combinationally in EXE; the flush takes effect on the next edge. A branch in ID/EXE while a MUL is in DONE cannot occur.

## Structure
- Shared package `exe_pkg` holds:
  - `exe_cmd` encodings as named constants;
  - `br` encodings;
  - FSM state enum `mul_state_t`.
- Sub-module `iter_mul` contains the FSM and datapath, with ports `start`, `a`, `b`, `busy`, `done`, `p`.
- The top level contains forwarding, the ALU, branch logic and stall gating.

## Test plan
- ADD: `data1`=5, `data2`=7, `imm`=1 -> `alu_result`=12, `stall`=0, `br_taken`=0.
- Forward priority: `src1`=3, `mem_dest`=3 and `wb_dest`=3 both enabled, `mem_val`=0xAA, `wb_val`=0xBB, SUB with opB=0x0A -> result 0xA0. Repeat with `src1`=0 -> raw `data1` is used.
- MUL: opA=0xFFFFFFFF, opB=3 -> `stall` high exactly 33 cycles, wb/mem enables 0 during stall, then `alu_result`=0xFFFFFFFD with `wb_en_out`=1 for one cycle.
- `rst` asserted at BUSY cycle 10 -> next cycle `stall`=0 and state IDLE. A fresh MUL of 6×7 gives 42 after 33 stall cycles.
- BNE: opA=4, forwarded `st_val`=4 -> not taken. With `st_val`=5, `pc_in`=0x100, `data2`=0x20 -> `br_taken`=1, `br_addr`=0x120.
- SRA: opA=0x80000000, opB=4 -> 0xF8000000. SLT with -1 vs 1 -> 1. `exe_cmd`=1111 -> 0.
